ctrl_decode_stage: RTL and testbench
====================================

Name: ctrl_decode_stage

Overview:
- Parametrised successor to the pipelined main/ALU decoder.
- Decodes RV32I and, optionally, RV32M instructions in the D stage.
- Owns the D→E control pipeline register, with stall and flush inputs.
- Sequences multi-cycle multiply/divide ops through a busy FSM that stalls the front end; sits between the instruction register and the execute-stage datapath.

Parameters:
- MUL_LATENCY, 1: cycles a MUL* op occupies E (≥1).
- DIV_LATENCY, 32: cycles a DIV*/REM* op occupies E (≥1).
- CNT_W, $clog2(DIV_LATENCY+1): busy counter width; must also hold MUL_LATENCY.

Ports:
- clk  in  1: clock.
- reset  in  1: synchronous, active-high.
- InstrD  in  32: D-stage instruction.
- ValidD  in  1: InstrD holds a real instruction.
- StallE  in  1: hazard unit holds the E register.
- FlushE  in  1: hazard unit clears the E register (bubble).
- ImmSrcD  out  3: combinational; I=000, S=001, B=010, J=011, U=100.
- IllegalD  out  1: combinational; ValidD and the opcode/funct combination is unsupported.
- RegWriteE, MemWriteE, JumpE, JumpRegE, BranchE, ALUSrcE, InverseBrCondE  out  1 each: registered E controls.
- ResultSrcE  out  2: 00 ALU, 01 memory, 10 PC+4, 11 MD unit.
- ALUControlE  out  4: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001, LUI-pass 1010.
- MdValidE  out  1: E holds an M op.
- MdOpE  out  3: funct3 of the M op.
- MdBusy  out  1: stall request to the F/D stages and the hazard unit.

Behaviour:
- Decode is purely combinational from InstrD.
- Supported: R, I-ALU, load, store, branch, JAL, JALR, LUI, AUIPC.
- Branches: BNE, BGE and BGEU set InverseBrCond=1.
- JALR sets both Jump and JumpReg.
- Illegal or !ValidD: all write/jump/branch controls decode to 0, so a bubble is loaded; IllegalD is asserted only when ValidD=1.
- E register update priority per clock edge:
  - reset: all E outputs 0, FSM=IDLE, counter=0.
  - FlushE: E controls cleared, FSM=IDLE, counter=0. Aborts an in-flight M op.
  - StallE or MdBusy: hold all E contents.
  - Otherwise: load the decoded D controls.
- Latency: the D decode appears on the E outputs 1 cycle after the load edge.
- FSM states:
  - IDLE → BUSY on a load edge where the loaded op is M with latency L>1; the counter is set to L-1. MUL* uses MUL_LATENCY; funct3[2]=1 (DIV/DIVU/REM/REMU) uses DIV_LATENCY.
  - BUSY: counter decrements each edge. At counter==1, the next edge goes to IDLE with counter 0.
  - MdBusy = (state==BUSY). It is asserted the cycle the op appears in E and stays high for exactly L-1 cycles, so the op occupies E for L cycles total.
  - An M op with L=1 never enters BUSY.
- StallE asserted during BUSY: the counter still decrements; E is held anyway.
- The cycle MdBusy deasserts, the next load edge advances normally.
- Back-to-back M ops: the second loads only after MdBusy drops, then starts its own count.
- M ops set RegWrite=1, ResultSrc=11, MdValidE=1 and ALUControl=ADD (don't-care).
- MdValidE/MdOpE are 0 for non-M ops.

Optional Feature:
- Macro RV32M_EN.
- Defined: opcode 0110011 with funct7=0000001 decodes as an M op, with FSM behaviour as above.
- Undefined:
  - Those encodings raise IllegalD and load a bubble.
  - MdValidE, MdOpE and MdBusy are tied to 0.
  - The FSM and counter are not instantiated.

Test Plan:
- Reset held 2 cycles, then released: all E outputs 0 and MdBusy=0; InstrD=0x002081B3 (add) loads → next cycle RegWriteE=1, ALUControlE=0000, ResultSrcE=00.
- InstrD=0x00209463 (bne) → ImmSrcD=010; next cycle BranchE=1, InverseBrCondE=1, ALUControlE=0001. InstrD=0x00008067 (jalr) → JumpE=JumpRegE=1, ResultSrcE=10.
- With RV32M_EN and DIV_LATENCY=32: InstrD=0x0220C1B3 (div) → MdValidE=1, MdOpE=100, MdBusy high for exactly 31 cycles, E held; the following add loads on the edge after MdBusy falls.
- With MUL_LATENCY=1: InstrD=0x022081B3 (mul) → MdValidE=1 for 1 cycle, MdBusy never asserted.
- Div in BUSY with counter=20, FlushE pulsed → next cycle MdBusy=0 and all E controls 0. Repeat with reset instead of FlushE → same result.
- InstrD=0xFFFFFFFF, ValidD=1 → IllegalD=1 and the E bubble is all-zero. Without RV32M_EN, 0x0220C1B3 → IllegalD=1 and MdBusy stays 0.

Source files
------------

// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage
//   D-stage main/ALU decoder for RV32I (plus RV32M when RV32M_EN is defined),
//   the D->E control pipeline register, and a busy FSM that holds the front
//   end while a multi-cycle multiply/divide occupies E.
//
// Optional feature macro: RV32M_EN
//   defined   : opcode 0110011 / funct7 0000001 decodes as an M op and the
//               busy FSM + counter are built.
//   undefined : those encodings are illegal; MdValidE, MdOpE, MdBusy tie to 0.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   InstrD, ValidD    D-stage instruction and its valid qualifier
//   StallE, FlushE    hazard unit hold / bubble requests for the E register
//   ImmSrcD           combinational immediate format (I=000 S=001 B=010 J=011 U=100)
//   IllegalD          combinational: ValidD with an unsupported encoding
//   *E                registered E-stage controls
//   MdValidE, MdOpE   E holds an M op, and its funct3
//   MdBusy            stall request while an M op is still executing
//
// Handshake: the E register loads the decoded D controls on an edge where
// neither StallE nor MdBusy is high; FlushE overrides both and loads a bubble.
// MdBusy is the busy-state flag itself, so it also serves as the FSM debug view.

module ctrl_decode_stage #(
    parameter int MUL_LATENCY = 1,
    parameter int DIV_LATENCY = 32,
    parameter int CNT_W       = $clog2(DIV_LATENCY + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic        ValidD,
    input  logic        StallE,
    input  logic        FlushE,
    output logic [2:0]  ImmSrcD,
    output logic        IllegalD,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        JumpE,
    output logic        JumpRegE,
    output logic        BranchE,
    output logic        ALUSrcE,
    output logic        InverseBrCondE,
    output logic [1:0]  ResultSrcE,
    output logic [3:0]  ALUControlE,
    output logic        MdValidE,
    output logic [2:0]  MdOpE,
    output logic        MdBusy
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1010;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign funct7 = InstrD[31:25];

    // Register numbers are consumed by the datapath, not by this decoder.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{InstrD[24:15], InstrD[11:7]};

    // funct3 -> ALU op for the non-alternate R / I-ALU encodings.
    function automatic logic [3:0] alu_base(input logic [2:0] f3);
        case (f3)
            3'b000:  alu_base = ALU_ADD;
            3'b001:  alu_base = ALU_SLL;
            3'b010:  alu_base = ALU_SLT;
            3'b011:  alu_base = ALU_SLTU;
            3'b100:  alu_base = ALU_XOR;
            3'b101:  alu_base = ALU_SRL;
            3'b110:  alu_base = ALU_OR;
            default: alu_base = ALU_AND;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic       legal;
    logic       dec_reg_write, dec_mem_write, dec_jump, dec_jump_reg;
    logic       dec_branch, dec_alu_src, dec_inv_br;
    logic [1:0] dec_result_src;
    logic [3:0] dec_alu_ctrl;
    logic       dec_md_valid;

    always_comb begin
        legal          = 1'b0;
        ImmSrcD        = 3'b000;
        dec_reg_write  = 1'b0;
        dec_mem_write  = 1'b0;
        dec_jump       = 1'b0;
        dec_jump_reg   = 1'b0;
        dec_branch     = 1'b0;
        dec_alu_src    = 1'b0;
        dec_inv_br     = 1'b0;
        dec_result_src = 2'b00;
        dec_alu_ctrl   = ALU_ADD;
        dec_md_valid   = 1'b0;

        case (opcode)
            OP_R: begin
                dec_reg_write = 1'b1;
                if (funct7 == 7'b0000000) begin
                    legal        = 1'b1;
                    dec_alu_ctrl = alu_base(funct3);
                end else if (funct7 == 7'b0100000 &&
                             (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    legal        = 1'b1;
                    dec_alu_ctrl = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
                end
`ifdef RV32M_EN
                else if (funct7 == 7'b0000001) begin
                    legal          = 1'b1;
                    dec_md_valid   = 1'b1;
                    dec_result_src = 2'b11;
                    dec_alu_ctrl   = ALU_ADD;
                end
`endif
            end
            OP_I_ALU: begin
                ImmSrcD       = 3'b000;
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                // Shift-immediates carry funct7 in imm[11:5]; only SRAI may set bit 5.
                if (funct3 == 3'b001)
                    legal = (funct7 == 7'b0000000);
                else if (funct3 == 3'b101)
                    legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                else
                    legal = 1'b1;
                dec_alu_ctrl = (funct3 == 3'b101 && funct7[5]) ? ALU_SRA : alu_base(funct3);
            end
            OP_LOAD: begin
                ImmSrcD        = 3'b000;
                legal          = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
                dec_reg_write  = 1'b1;
                dec_alu_src    = 1'b1;
                dec_result_src = 2'b01;
            end
            OP_STORE: begin
                ImmSrcD       = 3'b001;
                legal         = !funct3[2] && (funct3 != 3'b011);
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
            end
            OP_BRANCH: begin
                ImmSrcD    = 3'b010;
                legal      = (funct3[2:1] != 2'b01);
                dec_branch = 1'b1;
                // BNE/BGE/BGEU are the odd funct3 codes: same compare, inverted sense.
                dec_inv_br   = funct3[0];
                dec_alu_ctrl = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
            end
            OP_JAL: begin
                ImmSrcD        = 3'b011;
                legal          = 1'b1;
                dec_reg_write  = 1'b1;
                dec_jump       = 1'b1;
                dec_result_src = 2'b10;
            end
            OP_JALR: begin
                ImmSrcD        = 3'b000;
                legal          = (funct3 == 3'b000);
                dec_reg_write  = 1'b1;
                dec_jump       = 1'b1;
                dec_jump_reg   = 1'b1;
                dec_alu_src    = 1'b1;
                dec_result_src = 2'b10;
            end
            OP_LUI: begin
                ImmSrcD       = 3'b100;
                legal         = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_ctrl  = ALU_LUI;
            end
            OP_AUIPC: begin
                ImmSrcD       = 3'b100;
                legal         = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        // Anything not both valid and legal becomes a bubble.
        if (!(ValidD && legal)) begin
            dec_reg_write  = 1'b0;
            dec_mem_write  = 1'b0;
            dec_jump       = 1'b0;
            dec_jump_reg   = 1'b0;
            dec_branch     = 1'b0;
            dec_alu_src    = 1'b0;
            dec_inv_br     = 1'b0;
            dec_result_src = 2'b00;
            dec_alu_ctrl   = ALU_ADD;
            dec_md_valid   = 1'b0;
        end
    end

    assign IllegalD = ValidD && !legal;

    // ------------------------------------------------------------------
    // D->E control register
    // ------------------------------------------------------------------
    logic md_busy;
    logic load_e;
    assign load_e = !StallE && !md_busy;

    logic       reg_write_q, mem_write_q, jump_q, jump_reg_q, branch_q, alu_src_q, inv_br_q;
    logic       reg_write_d, mem_write_d, jump_d, jump_reg_d, branch_d, alu_src_d, inv_br_d;
    logic [1:0] result_src_q, result_src_d;
    logic [3:0] alu_ctrl_q, alu_ctrl_d;

    always_comb begin
        reg_write_d  = reg_write_q;
        mem_write_d  = mem_write_q;
        jump_d       = jump_q;
        jump_reg_d   = jump_reg_q;
        branch_d     = branch_q;
        alu_src_d    = alu_src_q;
        inv_br_d     = inv_br_q;
        result_src_d = result_src_q;
        alu_ctrl_d   = alu_ctrl_q;
        if (FlushE) begin
            reg_write_d  = 1'b0;
            mem_write_d  = 1'b0;
            jump_d       = 1'b0;
            jump_reg_d   = 1'b0;
            branch_d     = 1'b0;
            alu_src_d    = 1'b0;
            inv_br_d     = 1'b0;
            result_src_d = 2'b00;
            alu_ctrl_d   = 4'b0000;
        end else if (load_e) begin
            reg_write_d  = dec_reg_write;
            mem_write_d  = dec_mem_write;
            jump_d       = dec_jump;
            jump_reg_d   = dec_jump_reg;
            branch_d     = dec_branch;
            alu_src_d    = dec_alu_src;
            inv_br_d     = dec_inv_br;
            result_src_d = dec_result_src;
            alu_ctrl_d   = dec_alu_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            jump_q       <= 1'b0;
            jump_reg_q   <= 1'b0;
            branch_q     <= 1'b0;
            alu_src_q    <= 1'b0;
            inv_br_q     <= 1'b0;
            result_src_q <= 2'b00;
            alu_ctrl_q   <= 4'b0000;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            jump_q       <= jump_d;
            jump_reg_q   <= jump_reg_d;
            branch_q     <= branch_d;
            alu_src_q    <= alu_src_d;
            inv_br_q     <= inv_br_d;
            result_src_q <= result_src_d;
            alu_ctrl_q   <= alu_ctrl_d;
        end
    end

    assign RegWriteE      = reg_write_q;
    assign MemWriteE      = mem_write_q;
    assign JumpE          = jump_q;
    assign JumpRegE       = jump_reg_q;
    assign BranchE        = branch_q;
    assign ALUSrcE        = alu_src_q;
    assign InverseBrCondE = inv_br_q;
    assign ResultSrcE     = result_src_q;
    assign ALUControlE    = alu_ctrl_q;

    // ------------------------------------------------------------------
    // Multiply/divide sequencing
    // ------------------------------------------------------------------
`ifdef RV32M_EN
    typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_e;

    localparam logic [CNT_W-1:0] MUL_LAT_C = CNT_W'(MUL_LATENCY);
    localparam logic [CNT_W-1:0] DIV_LAT_C = CNT_W'(DIV_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    md_state_e        md_state_q, md_state_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic             md_valid_q, md_valid_d;
    logic [2:0]       md_op_q, md_op_d;
    logic [CNT_W-1:0] dec_md_lat;

    // funct3[2] separates DIV/DIVU/REM/REMU from the MUL family.
    assign dec_md_lat = funct3[2] ? DIV_LAT_C : MUL_LAT_C;

    always_comb begin
        md_state_d = md_state_q;
        md_cnt_d   = md_cnt_q;
        md_valid_d = md_valid_q;
        md_op_d    = md_op_q;
        if (FlushE) begin
            md_state_d = MD_IDLE;
            md_cnt_d   = '0;
            md_valid_d = 1'b0;
            md_op_d    = 3'b000;
        end else if (md_state_q == MD_BUSY) begin
            // Counter keeps running even if StallE is high; E is held regardless.
            if (md_cnt_q == CNT_ONE) begin
                md_state_d = MD_IDLE;
                md_cnt_d   = '0;
            end else begin
                md_cnt_d = md_cnt_q - CNT_ONE;
            end
        end else if (load_e) begin
            md_valid_d = dec_md_valid;
            md_op_d    = dec_md_valid ? funct3 : 3'b000;
            // Latency-1 ops finish inside their single E cycle and never go busy.
            if (dec_md_valid && dec_md_lat > CNT_ONE) begin
                md_state_d = MD_BUSY;
                md_cnt_d   = dec_md_lat - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_state_q <= MD_IDLE;
            md_cnt_q   <= '0;
            md_valid_q <= 1'b0;
            md_op_q    <= 3'b000;
        end else begin
            md_state_q <= md_state_d;
            md_cnt_q   <= md_cnt_d;
            md_valid_q <= md_valid_d;
            md_op_q    <= md_op_d;
        end
    end

    assign md_busy  = (md_state_q == MD_BUSY);
    assign MdValidE = md_valid_q;
    assign MdOpE    = md_op_q;
    assign MdBusy   = md_busy;
`else
    logic [31:0] unused_params;
    assign unused_params = 32'(MUL_LATENCY + DIV_LATENCY + CNT_W);
    assign md_busy  = 1'b0;
    assign MdValidE = 1'b0;
    assign MdOpE    = 3'b000;
    assign MdBusy   = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed bench for ctrl_decode_stage. Each step drives one D-stage input set,
// checks the combinational decode, pushes the E-stage bundle expected after the
// next rising edge, then pops and compares it once that edge has passed.
// E bundle layout: {RegWrite, MemWrite, Jump, JumpReg, Branch, ALUSrc,
//                   InverseBrCond, ResultSrc[1:0], ALUControl[3:0],
//                   MdValid, MdOp[2:0], MdBusy}

module tb_ctrl_decode_stage;

  localparam int MUL_LAT = 1;
  localparam int DIV_LAT = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrD;
  logic        ValidD;
  logic        StallE;
  logic        FlushE;
  logic [2:0]  ImmSrcD;
  logic        IllegalD;
  logic        RegWriteE, MemWriteE, JumpE, JumpRegE, BranchE, ALUSrcE, InverseBrCondE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic        MdValidE;
  logic [2:0]  MdOpE;
  logic        MdBusy;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ctrl_decode_stage #(
    .MUL_LATENCY (MUL_LAT),
    .DIV_LATENCY (DIV_LAT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .InstrD         (InstrD),
    .ValidD         (ValidD),
    .StallE         (StallE),
    .FlushE         (FlushE),
    .ImmSrcD        (ImmSrcD),
    .IllegalD       (IllegalD),
    .RegWriteE      (RegWriteE),
    .MemWriteE      (MemWriteE),
    .JumpE          (JumpE),
    .JumpRegE       (JumpRegE),
    .BranchE        (BranchE),
    .ALUSrcE        (ALUSrcE),
    .InverseBrCondE (InverseBrCondE),
    .ResultSrcE     (ResultSrcE),
    .ALUControlE    (ALUControlE),
    .MdValidE       (MdValidE),
    .MdOpE          (MdOpE),
    .MdBusy         (MdBusy)
  );

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  function automatic logic [17:0] ev(input logic rw, input logic mw, input logic jmp,
                                     input logic jreg, input logic br, input logic alusrc,
                                     input logic invbr, input logic [1:0] rsrc,
                                     input logic [3:0] aluc, input logic mdv,
                                     input logic [2:0] mdop, input logic busy);
    return {rw, mw, jmp, jreg, br, alusrc, invbr, rsrc, aluc, mdv, mdop, busy};
  endfunction

  function automatic logic [17:0] obs_e();
    return {RegWriteE, MemWriteE, JumpE, JumpRegE, BranchE, ALUSrcE, InverseBrCondE,
            ResultSrcE, ALUControlE, MdValidE, MdOpE, MdBusy};
  endfunction

  task automatic check_vec(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input string tag, input logic [31:0] instr, input logic valid,
                      input logic stall, input logic flush, input logic rst,
                      input logic [2:0] imm_exp, input logic ill_exp,
                      input logic [17:0] exp_e);
    logic [17:0] e;
    InstrD = instr;
    ValidD = valid;
    StallE = stall;
    FlushE = flush;
    reset  = rst;
    #1;
    checks++;
    assert ({ImmSrcD, IllegalD} === {imm_exp, ill_exp}) else begin
      failures++;
      $error("FAIL %s_dec observed=%b expected=%b", tag, {ImmSrcD, IllegalD}, {imm_exp, ill_exp});
    end
    exp_q.push_back(exp_e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_vec(tag, obs_e(), e);
  endtask

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_XOR  = 32'h0020C1B3;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BGEU = 32'h0020F463;
  localparam logic [31:0] I_JALR = 32'h00008067;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0030A023;
  localparam logic [31:0] I_SRAI = 32'h4020D193;
  localparam logic [31:0] I_LUI  = 32'h123451B7;
  localparam logic [31:0] I_DIV  = 32'h0220C1B3;
  localparam logic [31:0] I_MUL  = 32'h022081B3;
  localparam logic [31:0] I_ONES = 32'hFFFFFFFF;

  logic [17:0] z_e, add_e;
  int busy_cycles;

  initial begin
    z_e   = '0;
    add_e = ev(1, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 3'b000, 0);
    InstrD = '0; ValidD = 0; StallE = 0; FlushE = 0; reset = 1;

    // reset held two cycles
    step("rst0", 32'h0, 0, 0, 0, 1, 3'b000, 0, z_e);
    step("rst1", 32'h0, 0, 0, 0, 1, 3'b000, 0, z_e);

    // RV32I patterns
    step("add",  I_ADD,  1, 0, 0, 0, 3'b000, 0, add_e);
    step("bne",  I_BNE,  1, 0, 0, 0, 3'b010, 0, ev(0, 0, 0, 0, 1, 0, 1, 2'b00, 4'b0001, 0, 3'b000, 0));
    step("jalr", I_JALR, 1, 0, 0, 0, 3'b000, 0, ev(1, 0, 1, 1, 0, 1, 0, 2'b10, 4'b0000, 0, 3'b000, 0));
    step("lw",   I_LW,   1, 0, 0, 0, 3'b000, 0, ev(1, 0, 0, 0, 0, 1, 0, 2'b01, 4'b0000, 0, 3'b000, 0));
    step("sw",   I_SW,   1, 0, 0, 0, 3'b001, 0, ev(0, 1, 0, 0, 0, 1, 0, 2'b00, 4'b0000, 0, 3'b000, 0));
    step("sub",  I_SUB,  1, 0, 0, 0, 3'b000, 0, ev(1, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0001, 0, 3'b000, 0));
    step("xor",  I_XOR,  1, 0, 0, 0, 3'b000, 0, ev(1, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0100, 0, 3'b000, 0));
    step("srai", I_SRAI, 1, 0, 0, 0, 3'b000, 0, ev(1, 0, 0, 0, 0, 1, 0, 2'b00, 4'b1001, 0, 3'b000, 0));
    step("lui",  I_LUI,  1, 0, 0, 0, 3'b100, 0, ev(1, 0, 0, 0, 0, 1, 0, 2'b00, 4'b1010, 0, 3'b000, 0));
    step("jal",  I_JAL,  1, 0, 0, 0, 3'b011, 0, ev(1, 0, 1, 0, 0, 0, 0, 2'b10, 4'b0000, 0, 3'b000, 0));
    step("bgeu", I_BGEU, 1, 0, 0, 0, 3'b010, 0, ev(0, 0, 0, 0, 1, 0, 1, 2'b00, 4'b0110, 0, 3'b000, 0));
    step("beq",  I_BEQ,  1, 0, 0, 0, 3'b010, 0, ev(0, 0, 0, 0, 1, 0, 0, 2'b00, 4'b0001, 0, 3'b000, 0));

    // not valid -> bubble, no illegal flag
    step("novalid", I_ADD, 0, 0, 0, 0, 3'b000, 0, z_e);

    // stall holds, flush clears
    step("pre_stall", I_ADD, 1, 0, 0, 0, 3'b000, 0, add_e);
    step("stall",     I_SUB, 1, 1, 0, 0, 3'b000, 0, add_e);
    step("flush",     I_SUB, 1, 0, 1, 0, 3'b000, 0, z_e);

    // illegal encoding loads a bubble
    step("pre_ill",   I_ADD,  1, 0, 0, 0, 3'b000, 0, add_e);
    step("ill_ones",  I_ONES, 1, 0, 0, 0, 3'b000, 1, z_e);
    step("ones_nv",   I_ONES, 0, 0, 0, 0, 3'b000, 0, z_e);

`ifndef RV32M_EN
    step("pre_div_x", I_ADD, 1, 0, 0, 0, 3'b000, 0, add_e);
    step("div_ill",   I_DIV, 1, 0, 0, 0, 3'b000, 1, z_e);
    step("div_nobusy", I_DIV, 1, 0, 0, 0, 3'b000, 1, z_e);
    step("mul_ill",   I_MUL, 1, 0, 0, 0, 3'b000, 1, z_e);
`else
    // single-cycle multiply: MdValid for one cycle, never busy
    step("mul",       I_MUL, 1, 0, 0, 0, 3'b000, 0, ev(1, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0000, 1, 3'b000, 0));
    step("after_mul", I_ADD, 1, 0, 0, 0, 3'b000, 0, add_e);

    // divide: busy for DIV_LAT-1 cycles, stall mid-way does not extend it
    busy_cycles = 0;
    step("div", I_DIV, 1, 0, 0, 0, 3'b000, 0, ev(1, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0000, 1, 3'b100, 1));
    busy_cycles += int'(MdBusy);
    for (int k = 1; k < DIV_LAT - 1; k++) begin
      step("div_hold", I_ADD, 1, (k >= 10 && k < 20), 0, 0, 3'b000, 0,
           ev(1, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0000, 1, 3'b100, 1));
      busy_cycles += int'(MdBusy);
    end
    step("div_last", I_ADD, 1, 0, 0, 0, 3'b000, 0, ev(1, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0000, 1, 3'b100, 0));
    busy_cycles += int'(MdBusy);
    checks++;
    assert (busy_cycles === DIV_LAT - 1) else begin
      failures++;
      $error("FAIL div_busy_len observed=%0d expected=%0d", busy_cycles, DIV_LAT - 1);
    end
    step("div_next", I_ADD, 1, 0, 0, 0, 3'b000, 0, add_e);

    // flush aborts a divide with 20 cycles left
    step("div_f", I_DIV, 1, 0, 0, 0, 3'b000, 0, ev(1, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0000, 1, 3'b100, 1));
    for (int k = 0; k < 11; k++)
      step("div_f_hold", I_ADD, 1, 0, 0, 0, 3'b000, 0, ev(1, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0000, 1, 3'b100, 1));
    step("div_flush",  I_ADD, 1, 0, 1, 0, 3'b000, 0, z_e);
    step("post_flush", I_ADD, 1, 0, 0, 0, 3'b000, 0, add_e);

    // reset aborts a divide the same way
    step("div_r", I_DIV, 1, 0, 0, 0, 3'b000, 0, ev(1, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0000, 1, 3'b100, 1));
    for (int k = 0; k < 11; k++)
      step("div_r_hold", I_ADD, 1, 0, 0, 0, 3'b000, 0, ev(1, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0000, 1, 3'b100, 1));
    step("div_reset",  I_ADD, 1, 0, 0, 1, 3'b000, 0, z_e);
    step("post_reset", I_ADD, 1, 0, 0, 0, 3'b000, 0, add_e);
`endif

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
